// File: rtl/uart_responder.sv
// uart_responder: CPU-bus UART peripheral (rdn/wrn handshake, 8N1 serial TX and RX).
// Define UART_RX_FIFO_EN to replace the single receive buffer with an RX_FIFO_DEPTH-entry FIFO.

module uart_responder #(
  parameter int unsigned CLKS_PER_BIT  = 16,
  parameter int unsigned RX_FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wrn,
  input  logic       rdn,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       data_oe,
  output logic       data_ready,
  output logic       tbre,
  output logic       tsre,
  output logic       txd,
  input  logic       rxd,
  output logic       overrun
);

  localparam int unsigned        CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]   BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]   HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0) begin : g_bad_clks_per_bit
    $error("CLKS_PER_BIT must be >= 4 and even");
  end
  if (RX_FIFO_DEPTH < 2 || (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("RX_FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxBreak} rx_state_e;

  // Bus strobes
  logic wrn_q, rdn_q;
  logic wr_evt, rd_end;

  assign wr_evt  = wrn_q & ~wrn;
  assign rd_end  = ~rdn_q & rdn;
  assign data_oe = ~rdn;

  // Transmitter
  tx_state_e        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_idx_q, tx_idx_d;
  logic [7:0]       tsr_q, tsr_d, thr_q, thr_d;
  logic             tbre_q, tbre_d, tsre_q, tsre_d, txd_q, txd_d;
  logic             tx_bit_end, tx_load;

  assign tx_bit_end = (tx_cnt_q == BIT_LAST);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tsr_d      = tsr_q;
    thr_d      = thr_q;
    tbre_d     = tbre_q;
    tsre_d     = tsre_q;
    txd_d      = txd_q;
    tx_load    = 1'b0;

    if (wr_evt && tbre_q) begin
      thr_d  = data_i;
      tbre_d = 1'b0;
    end

    unique case (tx_state_q)
      TxIdle: tx_load = ~tbre_q;
      TxStart: begin
        tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
        if (tx_bit_end) begin
          txd_d      = tsr_q[0];
          tsr_d      = {1'b0, tsr_q[7:1]};
          tx_idx_d   = '0;
          tx_state_d = TxData;
        end
      end
      TxData: begin
        tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
        if (tx_bit_end) begin
          if (tx_idx_q == 3'd7) begin
            txd_d      = 1'b1;
            tx_state_d = TxStop;
          end else begin
            txd_d    = tsr_q[0];
            tsr_d    = {1'b0, tsr_q[7:1]};
            tx_idx_d = tx_idx_q + 1'b1;
          end
        end
      end
      TxStop: begin
        tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
        if (tx_bit_end) begin
          if (!tbre_q) begin
            tx_load = 1'b1;
          end else begin
            tsre_d     = 1'b1;
            tx_state_d = TxIdle;
          end
        end
      end
      default: tx_state_d = TxIdle;
    endcase

    // A pending holding-register byte starts its start bit on the next cycle.
    if (tx_load) begin
      tsr_d      = thr_q;
      tbre_d     = 1'b1;
      tsre_d     = 1'b0;
      txd_d      = 1'b0;
      tx_cnt_d   = '0;
      tx_state_d = TxStart;
    end
  end

  // Receiver
  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_idx_q, rx_idx_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_meta_q, rxs_q;
  logic             rx_bit_end, deliver;

  assign rx_bit_end = (rx_cnt_q == BIT_LAST);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    deliver    = 1'b0;

    unique case (rx_state_q)
      RxIdle: begin
        if (!rxs_q) begin
          rx_cnt_d   = '0;
          rx_state_d = RxStart;
        end
      end
      RxStart: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_idx_d   = '0;
          rx_state_d = rxs_q ? RxIdle : RxData;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxData: begin
        rx_cnt_d = rx_bit_end ? '0 : rx_cnt_q + 1'b1;
        if (rx_bit_end) begin
          rx_shift_d = {rxs_q, rx_shift_q[7:1]};
          rx_idx_d   = rx_idx_q + 1'b1;
          if (rx_idx_q == 3'd7) rx_state_d = RxStop;
        end
      end
      RxStop: begin
        rx_cnt_d = rx_bit_end ? '0 : rx_cnt_q + 1'b1;
        if (rx_bit_end) begin
          deliver    = rxs_q;
          rx_state_d = rxs_q ? RxIdle : RxBreak;
        end
      end
      RxBreak: if (rxs_q) rx_state_d = RxIdle;
      default: rx_state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrn_q      <= 1'b1;
      rdn_q      <= 1'b1;
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tsr_q      <= '0;
      thr_q      <= '0;
      tbre_q     <= 1'b1;
      tsre_q     <= 1'b1;
      txd_q      <= 1'b1;
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      wrn_q      <= wrn;
      rdn_q      <= rdn;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tsr_q      <= tsr_d;
      thr_q      <= thr_d;
      tbre_q     <= tbre_d;
      tsre_q     <= tsre_d;
      txd_q      <= txd_d;
      rx_meta_q  <= rxd;
      rxs_q      <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  assign tbre = tbre_q;
  assign tsre = tsre_q;
  assign txd  = txd_q;

`ifdef UART_RX_FIFO_EN
  localparam int unsigned AW        = $clog2(RX_FIFO_DEPTH);
  localparam logic [AW:0] FIFO_FULL = (AW + 1)'(RX_FIFO_DEPTH);

  logic [7:0]    mem_q [RX_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          fifo_full, fifo_empty, push, pop, overrun_q;

  assign fifo_full  = (count_q == FIFO_FULL);
  assign fifo_empty = (count_q == '0);
  assign pop        = rd_end & ~fifo_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign push       = deliver & (~fifo_full | pop);

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q     <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= rx_shift_q;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      if (deliver && fifo_full && !pop) overrun_q <= 1'b1;
    end
  end

  assign data_o     = mem_q[rd_ptr_q];
  assign data_ready = ~fifo_empty;
  assign overrun    = overrun_q;
`else
  logic [7:0] rbr_q;
  logic       ready_q, overrun_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rbr_q     <= '0;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else if (deliver) begin
      // The new byte wins over a simultaneous read; an unread old byte is lost.
      rbr_q   <= rx_shift_q;
      ready_q <= 1'b1;
      if (ready_q && !rd_end) overrun_q <= 1'b1;
    end else if (rd_end) begin
      ready_q <= 1'b0;
    end
  end

  assign data_o     = rbr_q;
  assign data_ready = ready_q;
  assign overrun    = overrun_q;
`endif

endmodule
